// File: rtl/bit5_pkg.sv
// Shared types and helpers for the five-buffer one-hot select decoder.
package bit5_pkg;

  localparam int BUF_MAX = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Out-of-range indices decode to all-zero so sel can never be multi-hot.
  function automatic logic [BUF_MAX-1:0] idx_to_onehot(input logic [2:0] i);
    logic [BUF_MAX-1:0] oh;
    oh = '0;
    if (i < 3'(BUF_MAX))
      oh = BUF_MAX'(1) << i;
    return oh;
  endfunction

endpackage

// File: rtl/bit5_decode.sv
// Frame-buffer rotation controller: tracks the active buffer index and drives a
// registered one-hot select with change and load-error pulses.
module bit5_decode
  import bit5_pkg::*;
#(
  parameter bit AUTO_START = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [2:0]   buf_num,
  input  logic [2:0]   idx,
  input  logic         idx_vld,
  input  logic         frame_done,
  output logic [4:0]   sel,
  output logic [2:0]   cur_idx,
  output logic         sel_vld,
  output logic         err
);

  state_t      state_reg, state_next;
  logic [2:0]  cur_idx_reg, cur_idx_next;
  logic [4:0]  sel_reg, sel_next;
  logic        sel_vld_reg, sel_vld_next;
  logic        err_reg, err_next;

  logic [2:0]  eff_num;
  logic [2:0]  adv_idx;
  logic        load_ok;

  always_comb begin
    eff_num = buf_num;
    if (buf_num == 3'd0)
      eff_num = 3'd1;
    else if (buf_num > 3'(BUF_MAX))
      eff_num = 3'(BUF_MAX);
  end

  assign load_ok = idx_vld && (idx < eff_num);
  assign adv_idx = (cur_idx_reg + 3'd1 >= eff_num) ? 3'd0 : cur_idx_reg + 3'd1;

  always_comb begin
    state_next   = state_reg;
    cur_idx_next = cur_idx_reg;
    err_next     = 1'b0;

    if (!en) begin
      state_next   = IDLE;
      cur_idx_next = 3'd0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          err_next = idx_vld && !load_ok;
          if (load_ok) begin
            state_next   = RUN;
            cur_idx_next = idx;
          end else if (frame_done || AUTO_START) begin
            state_next   = RUN;
            cur_idx_next = 3'd0;
          end
        end
        RUN: begin
          // Buffer count shrank under us: snap back to buffer 0 and ignore strobes.
          if (cur_idx_reg >= eff_num) begin
            cur_idx_next = 3'd0;
          end else if (load_ok) begin
            cur_idx_next = idx;
          end else begin
            err_next = idx_vld;
            if (frame_done)
              cur_idx_next = adv_idx;
          end
        end
        default: begin
          state_next   = IDLE;
          cur_idx_next = 3'd0;
        end
      endcase
    end

    sel_next     = (state_next == RUN) ? idx_to_onehot(cur_idx_next) : 5'b00000;
    sel_vld_next = (sel_next != sel_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cur_idx_reg <= 3'd0;
      sel_reg     <= 5'b00000;
      sel_vld_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_idx_reg <= cur_idx_next;
      sel_reg     <= sel_next;
      sel_vld_reg <= sel_vld_next;
      err_reg     <= err_next;
    end
  end

  assign sel     = sel_reg;
  assign cur_idx = cur_idx_reg;
  assign sel_vld = sel_vld_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_bit5_decode.sv
// Directed test of bit5_decode: loads, wrap, errors, shrink recovery, disable and reset.
module tb_bit5_decode;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] buf_num;
  logic [2:0] idx;
  logic       idx_vld;
  logic       frame_done;
  logic [4:0] sel;
  logic [2:0] cur_idx;
  logic       sel_vld;
  logic       err;

  int checks;
  int errors;

  bit5_decode #(.AUTO_START(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .buf_num    (buf_num),
    .idx        (idx),
    .idx_vld    (idx_vld),
    .frame_done (frame_done),
    .sel        (sel),
    .cur_idx    (cur_idx),
    .sel_vld    (sel_vld),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set after this take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    idx_vld    = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp_sel,
                           input logic [2:0] exp_idx, input logic exp_vld,
                           input logic exp_err);
    checks++;
    if (sel !== exp_sel || cur_idx !== exp_idx || sel_vld !== exp_vld || err !== exp_err) begin
      errors++;
      $display("FAIL %s: got sel=%b cur_idx=%0d sel_vld=%b err=%b, want sel=%b cur_idx=%0d sel_vld=%b err=%b",
               name, sel, cur_idx, sel_vld, err, exp_sel, exp_idx, exp_vld, exp_err);
    end else begin
      $display("ok   %s: sel=%b cur_idx=%0d sel_vld=%b err=%b", name, sel, cur_idx, sel_vld, err);
    end
  endtask

  task automatic do_load(input logic [2:0] i);
    idx = i; idx_vld = 1'b1;
    step();
    clear_strobes();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; buf_num = 3'd5; idx = 3'd0; clear_strobes();
    #3;
    check_out("reset_async", 5'b00000, 3'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_out("after_release_idle", 5'b00000, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_load();
    en = 1'b1; buf_num = 3'd5;
    do_load(3'd3);
    check_out("load3", 5'b01000, 3'd3, 1'b1, 1'b0);
    step();
    check_out("load3_hold", 5'b01000, 3'd3, 1'b0, 1'b0);
    do_load(3'd3);
    check_out("reload_same", 5'b01000, 3'd3, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_load(3'd4);
    check_out("load4", 5'b10000, 3'd4, 1'b1, 1'b0);
    frame_done = 1'b1; step(); clear_strobes();
    check_out("wrap_to0", 5'b00001, 3'd0, 1'b1, 1'b0);
    frame_done = 1'b1; step(); clear_strobes();
    check_out("advance_to1", 5'b00010, 3'd1, 1'b1, 1'b0);
  endtask

  task automatic test_invalid_load();
    buf_num = 3'd3;
    do_load(3'd4);
    check_out("invalid4_err", 5'b00010, 3'd1, 1'b0, 1'b1);
    step();
    check_out("invalid4_err_clears", 5'b00010, 3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_err_with_advance();
    idx = 3'd6; idx_vld = 1'b1; frame_done = 1'b1;
    step(); clear_strobes();
    check_out("invalid6_plus_advance", 5'b00100, 3'd2, 1'b1, 1'b1);
    frame_done = 1'b1; step(); clear_strobes();
    check_out("advance_wrap_n3", 5'b00001, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_load_wins();
    do_load(3'd1);
    idx = 3'd0; idx_vld = 1'b1; frame_done = 1'b1;
    step(); clear_strobes();
    check_out("load_beats_advance", 5'b00001, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_shrink();
    buf_num = 3'd5;
    do_load(3'd4);
    buf_num = 3'd2;
    step();
    check_out("shrink_recover", 5'b00001, 3'd0, 1'b1, 1'b0);
    buf_num = 3'd0;
    do_load(3'd1);
    check_out("bufnum0_as_1_err", 5'b00001, 3'd0, 1'b0, 1'b1);
    buf_num = 3'd7;
    do_load(3'd4);
    check_out("bufnum7_as_5_load4", 5'b10000, 3'd4, 1'b1, 1'b0);
  endtask

  task automatic test_disable_and_reset();
    buf_num = 3'd5;
    do_load(3'd2);
    check_out("load2", 5'b00100, 3'd2, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_out("disable_clears", 5'b00000, 3'd0, 1'b1, 1'b0);
    idx = 3'd7; idx_vld = 1'b1; frame_done = 1'b1;
    step(); clear_strobes();
    check_out("disabled_ignores", 5'b00000, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    frame_done = 1'b1; step(); clear_strobes();
    check_out("frame_done_starts", 5'b00001, 3'd0, 1'b1, 1'b0);
    do_load(3'd2);
    idx = 3'd4; idx_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_out("reset_midcycle", 5'b00000, 3'd0, 1'b0, 1'b0);
    step();
    clear_strobes();
    rst_n = 1'b1;
    step();
    check_out("post_reset_idle", 5'b00000, 3'd0, 1'b0, 1'b0);
    do_load(3'd1);
    check_out("post_reset_load1", 5'b00010, 3'd1, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_wrap();
    test_invalid_load();
    test_err_with_advance();
    test_load_wins();
    test_shrink();
    test_disable_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit5_decode.md
BIT5_DECODE -- requirements
Module: bit5_decode

Interface
REQ-001 Parameter AUTO_START, default 0: when 1, the block leaves IDLE on the first cycle that en=1, without waiting for a load or frame_done.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  block enable; low forces return to IDLE.
REQ-005 buf_num  input  3  number of frame buffers in rotation; legal range 1..5.
REQ-006 idx  input  3  buffer index to load; sampled when idx_vld=1.
REQ-007 idx_vld  input  1  single-cycle load strobe for idx.
REQ-008 frame_done  input  1  single-cycle pulse requesting advance to the next buffer.
REQ-009 sel  output  5  registered one-hot buffer select; bit n set means buffer n is active.
REQ-010 cur_idx  output  3  registered binary index of the active buffer.
REQ-011 sel_vld  output  1  one-cycle pulse marking a change of sel.
REQ-012 err  output  1  one-cycle pulse marking a rejected load.

Function
REQ-013 Effective buffer count: buf_num=0 is treated as 1; buf_num>5 is treated as 5 (eff_num).
REQ-014 FSM states:
  - IDLE: sel=0, cur_idx=0.
  - RUN: sel=1<<cur_idx.
REQ-015 IDLE->RUN occurs on any of:
  - a valid load;
  - frame_done=1 with en=1, which loads index 0;
  - AUTO_START=1 with en=1, which loads index 0.
REQ-016 RUN->IDLE occurs on the clock after en=0; the clock after en=0 also sets sel=0 and cur_idx=0, and pulses sel_vld if sel was nonzero.
REQ-017 While en=0, idx_vld and frame_done are ignored: no err and no state change.
REQ-018 A load is valid when idx<eff_num; the registered result is cur_idx=idx and sel=1<<idx, one cycle after the strobe.
REQ-019 An invalid load (idx>=eff_num, including 5..7):
  - err=1 for exactly one cycle, one cycle after the strobe;
  - sel and cur_idx unchanged.
REQ-020 In RUN, frame_done advances cur_idx to cur_idx+1, wrapping to 0 when cur_idx+1>=eff_num; sel follows with the same one-cycle latency.
REQ-021 Simultaneous valid load and frame_done: the load wins and the frame_done is discarded.
REQ-022 Simultaneous invalid load and frame_done: err pulses and the advance still occurs.
REQ-023 If eff_num drops so that cur_idx>=eff_num while in RUN, the next cycle forces cur_idx=0 and sel=5'b00001, with a sel_vld pulse; this shrink recovery takes priority over load and frame_done in that cycle.
REQ-024 sel_vld pulses only when the registered sel value differs from its previous value; reloading the same index produces no pulse.
REQ-025 sel is always zero or exactly one-hot; no other value is legal.

Reset
REQ-026 rst_n low asynchronously forces:
  - state=IDLE;
  - sel=5'b00000, cur_idx=3'd0;
  - sel_vld=0, err=0.
REQ-027 Reset asserted mid-operation discards any pending strobe; after release the block behaves as from power-up.

Structure
REQ-028 Package bit5_pkg holds the IDLE/RUN state encoding, constant BUF_MAX=5, and the index-to-one-hot decode function.
REQ-029 No sub-module; single flat module.

Verification
REQ-030 Reset, then en=1, buf_num=5, idx=3 with idx_vld -> next cycle sel=5'b01000, cur_idx=3, sel_vld=1, err=0.
REQ-031 Running at cur_idx=4 with buf_num=5, then frame_done -> sel=5'b00001, cur_idx=0, sel_vld=1 (wrap).
REQ-032 buf_num=3, idx=4 with idx_vld -> err=1 for one cycle, sel unchanged.
REQ-033 buf_num=3, idx=6 with idx_vld and frame_done in the same cycle, from cur_idx=1 -> err=1 and cur_idx=2, sel=5'b00100.
REQ-034 Running at cur_idx=4, then buf_num changes to 2 -> next cycle cur_idx=0, sel=5'b00001, sel_vld=1.
REQ-035 Running at cur_idx=2, then en=0 -> next cycle sel=0, sel_vld=1; then rst_n pulsed low mid-cycle -> outputs zero immediately, without waiting for a clock edge.
